// File: rtl/instruction_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instruction_pkg                                                |
// | Brief   : Shared fetch FSM state type and fetch reset constants.         |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package instruction_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam int          FETCH_ENTRY_W  = 64;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fetch_fifo                                                     |
// | Brief   : Power-of-two fetch buffer holding {pc, inst} entries.          |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Flush wins over any same-cycle push/pop.
   assign w_push    = push & ~flush & (r_count != c_depth);
   assign w_pop     = pop  & ~flush & (r_count != '0);
   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign empty     = (r_count == '0);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instruction_fetch                                              |
// | Brief   : Credit-based instruction fetch with redirect flush; optional   |
// |           same-cycle response bypass enabled by FETCH_BYPASS_EN.         |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module instruction_fetch
   import instruction_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_v_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic        inst_rdy_i,
   input  logic        pc_v_x,
   input  logic [31:0] pc_x
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] c_depth = (CW+1)'(FIFO_DEPTH);

   fetch_state_e r_state;
   fetch_state_e w_state_next;
   logic [31:0]  r_fetch_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard_cnt;
   logic [CW-1:0] w_discard_next;
   logic [CW-1:0] w_fifo_count;
   logic [31:0]  w_rsp_pc;
   logic [FETCH_ENTRY_W-1:0] w_head;
   logic w_rsp, w_grant, w_credit, w_push, w_pop, w_bypass, w_fifo_empty;
   logic w_unused_pc_lsb;

   assign w_unused_pc_lsb = ^pc_x[1:0];

   // Responses with nothing outstanding (pre-reset traffic) are ignored.
   assign w_rsp          = imem_rvalid_i & (r_outstanding != '0);
   assign w_discard_next = r_outstanding - CW'(w_rsp);
   assign w_credit       = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < c_depth;
   // Responses return in order, so the oldest outstanding address is behind fetch_pc.
   assign w_rsp_pc       = r_fetch_pc - (32'(r_outstanding) << 2);
   assign imem_addr_o    = r_fetch_pc;
   assign w_grant        = imem_req_o & imem_gnt_i;

   always_comb begin
      w_state_next = r_state;
      imem_req_o   = 1'b0;
      if (pc_v_x) begin
         w_state_next = (w_discard_next != '0) ? FLUSH : RUN;
      end else begin
         case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     imem_req_o   = w_credit;
            FLUSH:   if (w_rsp && (r_discard_cnt == CW'(1))) w_state_next = RUN;
            default: w_state_next = BOOT;
         endcase
      end
   end

`ifdef FETCH_BYPASS_EN
   assign w_bypass = (r_state == RUN) & w_rsp & w_fifo_empty & inst_rdy_i & ~pc_v_x;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push   = (r_state == RUN) & w_rsp & ~pc_v_x & ~w_bypass;
   assign inst_v_o = (~w_fifo_empty | w_bypass) & ~pc_v_x;
   assign inst_o   = w_bypass ? imem_rdata_i : w_head[31:0];
   assign pc_o     = w_bypass ? w_rsp_pc     : w_head[63:32];
   assign w_pop    = inst_v_o & inst_rdy_i & ~w_bypass;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= BOOT;
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_discard_cnt <= '0;
      end else begin
         r_state       <= w_state_next;
         r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
         if (pc_v_x)       r_fetch_pc <= {pc_x[31:2], 2'b00};
         else if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (pc_v_x)
            r_discard_cnt <= w_discard_next;
         else if ((r_state == FLUSH) && w_rsp)
            r_discard_cnt <= r_discard_cnt - CW'(1);
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (pc_v_x),
      .push      (w_push),
      .push_data ({w_rsp_pc, imem_rdata_i}),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_fifo_count),
      .empty     (w_fifo_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_instruction_fetch                                           |
// | Brief   : Randomized bench for instruction_fetch against a queue model.  |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        inst_v_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_rdy_i;
   logic        pc_v_x;
   logic [31:0] pc_x;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .inst_v_o(inst_v_o), .inst_o(inst_o), .pc_o(pc_o), .inst_rdy_i(inst_rdy_i),
      .pc_v_x(pc_v_x), .pc_x(pc_x)
   );

   typedef struct packed { logic [31:0] addr; logic stale; } pend_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem_q[$];      // addresses the memory still owes a response for
   pend_t       m_pend[$];     // model: in-flight requests, stale after redirect
   logic [63:0] m_fifo[$];     // model: buffered {pc, inst}
   logic [31:0] m_pc;
   bit          m_boot;
   logic [31:0] dlog[$];       // model pcs handed to execution
   bit          last_req;
   logic [31:0] last_addr;
   int          grants;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0DE};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit g, input bit rv_en, input bit rdy, input bit pcv,
                        input logic [31:0] pcx);
      bit e_req, e_v, byp, rv;
      int stale;
      logic [31:0] e_inst, e_pc;
      pend_t p;
      imem_gnt_i    = g;
      inst_rdy_i    = rdy;
      pc_v_x        = pcv;
      pc_x          = pcx;
      rv            = rv_en && (mem_q.size() > 0);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_data(mem_q[0]) : $urandom;
      #2;
      stale = 0;
      foreach (m_pend[i]) if (m_pend[i].stale) stale++;
      e_req = !m_boot && stale == 0 && !pcv && (m_pend.size() + m_fifo.size() < DEPTH);
      byp = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp = !m_boot && stale == 0 && m_fifo.size() == 0 && rdy && !pcv && rv;
`endif
      e_v = (m_fifo.size() > 0 || byp) && !pcv;
      e_inst = 32'h0;
      e_pc   = 32'h0;
      if (byp) begin
         e_pc   = m_pend[0].addr;
         e_inst = mem_data(m_pend[0].addr);
      end else if (m_fifo.size() > 0) begin
         e_pc   = m_fifo[0][63:32];
         e_inst = m_fifo[0][31:0];
      end
      chk("imem_req_o", {31'b0, imem_req_o}, {31'b0, e_req});
      if (e_req) chk("imem_addr_o", imem_addr_o, m_pc);
      chk("inst_v_o", {31'b0, inst_v_o}, {31'b0, e_v});
      if (e_v) begin
         chk("inst_o", inst_o, e_inst);
         chk("pc_o", pc_o, e_pc);
         if (rdy) dlog.push_back(e_pc);
      end
      last_req  = imem_req_o;
      last_addr = imem_addr_o;
      if (last_req && g) grants++;
      @(posedge clk);
      if (rv) void'(mem_q.pop_front());
      if (last_req && g) mem_q.push_back(last_addr);
      if (e_v && rdy && !byp) void'(m_fifo.pop_front());
      if (rv && m_pend.size() > 0) begin
         p = m_pend.pop_front();
         if (!p.stale && !pcv && !byp) m_fifo.push_back({p.addr, mem_data(p.addr)});
      end
      if (e_req && g) begin
         m_pend.push_back('{addr: m_pc, stale: 1'b0});
         m_pc = m_pc + 32'd4;
      end
      if (pcv) begin
         m_fifo.delete();
         foreach (m_pend[i]) m_pend[i].stale = 1'b1;
         m_pc = {pcx[31:2], 2'b00};
      end
      m_boot = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      inst_rdy_i = 1'b1; pc_v_x = 1'b0; pc_x = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req", {31'b0, imem_req_o}, 32'd0);
      chk("reset_inst_v", {31'b0, inst_v_o}, 32'd0);
      reset = 1'b0;
      mem_q.delete(); m_pend.delete(); m_fifo.delete();
      m_pc = 32'h0; m_boot = 1'b1;
   endtask

   task automatic drain();
      repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
      chk({name, "_avail"}, {31'b0, dlog.size() > idx}, 32'd1);
      if (dlog.size() > idx) chk(name, dlog[idx], exp);
   endtask

   initial begin
      do_reset();
      // Zero-wait fill from reset
      dlog.delete();
      repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("seq0", 0, 32'h0); chk_log("seq1", 1, 32'h4);
      chk_log("seq2", 2, 32'h8); chk_log("seq3", 3, 32'hC);

      // Grant withheld: address must hold
      drain();
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         chk("nogrant_addr", last_addr, 32'h40);
      end
      dlog.delete();
      repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("nogrant_first", 0, 32'h40);

      // Misaligned redirect target
      drain();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h202);
      dlog.delete();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("align_req", {31'b0, last_req}, 32'd1);
      chk("align_addr", last_addr, 32'h200);
      repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("align_pc", 0, 32'h200);

      // Redirect with two outstanding: both dropped
      drain();
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("outstanding", mem_q.size(), 32'd2);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
      dlog.delete();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("flush_noreq", {31'b0, last_req}, 32'd0);
      repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("flush_pc", 0, 32'h100);

      // Execution stall: credit caps requests, order kept
      drain();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
      grants = 0;
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_grants", grants, DEPTH);
      dlog.delete();
      repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("stall0", 0, 32'h300); chk_log("stall1", 1, 32'h304);
      chk_log("stall2", 2, 32'h308);

      // Address wrap
      drain();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      dlog.delete();
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_log("wrap0", 0, 32'hFFFF_FFF8); chk_log("wrap1", 1, 32'hFFFF_FFFC);
      chk_log("wrap2", 2, 32'h0000_0000);

      // Random traffic with a mid-run reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
               ($urandom % 20) == 0, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
